// File: rtl/i2c_pkg.sv
// i2c_pkg: shared I2C definitions (target FSM encoding, default address, master-side constants)
package i2c_pkg;

    localparam logic [6:0] I2C_DEF_TARGET_ADDR = 7'h27;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_ADDR     = 3'd1;
    localparam logic [2:0] ST_ADDR_ACK = 3'd2;
    localparam logic [2:0] ST_DATA     = 3'd3;
    localparam logic [2:0] ST_DATA_ACK = 3'd4;
    localparam logic [2:0] ST_IGNORE   = 3'd5;

    typedef enum logic [1:0] {
        I2C_CMD_START,
        I2C_CMD_WRITE,
        I2C_CMD_READ,
        I2C_CMD_STOP
    } i2c_cmd_e;

    localparam int unsigned I2C_MST_CLKDIV_DEF = 250;

    function automatic logic addr_hit(input logic [7:0] b, input logic [6:0] a);
        return (b[7:1] == a) && !b[0];
    endfunction

endpackage

// File: rtl/i2c_in_filter.sv
// i2c_in_filter: 2-FF synchronizer for one bus line, plus glitch filter when I2C_TARGET_FILTER_EN is defined
module i2c_in_filter #(
    parameter int FILT_CYC = 4
) (
    input  logic clk,
    input  logic reset_p,
    input  logic i_line,
    output logic o_line
);

    logic [1:0] sync_q;

    // Two-flop synchronizer; resets to the idle-high bus level
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) sync_q <= 2'b11;
        else         sync_q <= {sync_q[0], i_line};
    end

`ifdef I2C_TARGET_FILTER_EN
    localparam int CW = $clog2(FILT_CYC + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          line_q, line_d;

    // Count consecutive samples disagreeing with the filtered level; flip after FILT_CYC of them
    always_comb begin
        cnt_d  = (sync_q[1] == line_q) ? '0 : cnt_q + 1'b1;
        line_d = line_q;
        if (cnt_d == CW'(FILT_CYC)) begin
            line_d = sync_q[1];
            cnt_d  = '0;
        end
    end

    // Filter state registers
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            cnt_q  <= '0;
            line_q <= 1'b1;
        end else begin
            cnt_q  <= cnt_d;
            line_q <= line_d;
        end
    end

    assign o_line = line_q;
`else
    logic unused_cfg;
    assign unused_cfg = (FILT_CYC == 0);
    assign o_line     = sync_q[1];
`endif

endmodule

// File: rtl/i2c_target_rx.sv
// i2c_target_rx: write-only I2C target receiver; optional input glitch filter via I2C_TARGET_FILTER_EN
module i2c_target_rx
    import i2c_pkg::*;
#(
    parameter logic [6:0] TARGET_ADDR = I2C_DEF_TARGET_ADDR,
    parameter int         FILT_CYC    = 4
) (
    input  logic       clk,
    input  logic       reset_p,
    input  logic       i_scl,
    input  logic       i_sda,
    output logic       o_sda_oe,
    output logic [7:0] o_data,
    output logic       o_valid,
    output logic       o_busy,
    output logic       o_stop
);

    logic       scl, sda;
    logic       scl_q, sda_q;
    logic       scl_rise, scl_fall, start_c, stop_c;
    logic [7:0] byte_w;

    logic [2:0] state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] data_q, data_d;
    logic       valid_q, valid_d;
    logic       oe_q, oe_d;
    logic       busy_q, busy_d;
    logic       stop_q, stop_d;

    i2c_in_filter #(.FILT_CYC(FILT_CYC)) u_scl_filt (
        .clk     (clk),
        .reset_p (reset_p),
        .i_line  (i_scl),
        .o_line  (scl)
    );

    i2c_in_filter #(.FILT_CYC(FILT_CYC)) u_sda_filt (
        .clk     (clk),
        .reset_p (reset_p),
        .i_line  (i_sda),
        .o_line  (sda)
    );

    // Previous line levels for edge and START/STOP detection
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            scl_q <= 1'b1;
            sda_q <= 1'b1;
        end else begin
            scl_q <= scl;
            sda_q <= sda;
        end
    end

    assign scl_rise = scl & ~scl_q;
    assign scl_fall = ~scl & scl_q;
    assign start_c  = scl & scl_q & sda_q & ~sda;
    assign stop_c   = scl & scl_q & ~sda_q & sda;
    assign byte_w   = {shift_q[6:0], sda};

    // Next-state logic: STOP and START override every state; ACK phases use oe_q as their half-step flag
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        oe_d    = oe_q;
        busy_d  = busy_q;
        stop_d  = 1'b0;
        if (stop_c) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            shift_d = '0;
            oe_d    = 1'b0;
            busy_d  = 1'b0;
            stop_d  = 1'b1;
        end else if (start_c) begin
            state_d = ST_ADDR;
            cnt_d   = '0;
            shift_d = '0;
            oe_d    = 1'b0;
        end else begin
            case (state_q)
                ST_ADDR: if (scl_rise) begin
                    shift_d = byte_w;
                    cnt_d   = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        state_d = addr_hit(byte_w, TARGET_ADDR) ? ST_ADDR_ACK : ST_IGNORE;
                        busy_d  = addr_hit(byte_w, TARGET_ADDR);
                    end
                end
                ST_DATA: if (scl_rise) begin
                    shift_d = byte_w;
                    cnt_d   = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        data_d  = byte_w;
                        valid_d = 1'b1;
                        state_d = ST_DATA_ACK;
                    end
                end
                ST_ADDR_ACK, ST_DATA_ACK: if (scl_fall) begin
                    oe_d    = ~oe_q;
                    cnt_d   = '0;
                    state_d = oe_q ? ST_DATA : state_q;
                end
                default: ;
            endcase
        end
    end

    // State registers; asynchronous reset releases SDA immediately
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            oe_q    <= 1'b0;
            busy_q  <= 1'b0;
            stop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            oe_q    <= oe_d;
            busy_q  <= busy_d;
            stop_q  <= stop_d;
        end
    end

    assign o_sda_oe = oe_q;
    assign o_data   = data_q;
    assign o_valid  = valid_q;
    assign o_busy   = busy_q;
    assign o_stop   = stop_q;

endmodule

// File: tb/tb_i2c_target_rx.sv
// tb_i2c_target_rx: directed bus-master bench with a scoreboard of expected received bytes
module tb_i2c_target_rx;

    localparam int Q = 8;

    logic       clk = 1'b0;
    logic       reset_p = 1'b1;
    logic       m_scl = 1'b1;
    logic       m_sda = 1'b1;
    logic       i_sda;
    logic       o_sda_oe, o_valid, o_busy, o_stop;
    logic [7:0] o_data;

    int   passed = 0;
    int   failed = 0;
    int   total = 0;
    int   n_valid = 0;
    int   n_stop = 0;
    logic busy_seen = 1'b0;
    logic [7:0] exp_q[$];

    assign i_sda = m_sda & ~o_sda_oe;

    always #5 clk = ~clk;

    i2c_target_rx #(.TARGET_ADDR(7'h27), .FILT_CYC(4)) dut (
        .clk      (clk),
        .reset_p  (reset_p),
        .i_scl    (m_scl),
        .i_sda    (i_sda),
        .o_sda_oe (o_sda_oe),
        .o_data   (o_data),
        .o_valid  (o_valid),
        .o_busy   (o_busy),
        .o_stop   (o_stop)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wq(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_start();
        m_sda = 1'b1; wq(Q);
        m_scl = 1'b1; wq(Q);
        m_sda = 1'b0; wq(Q);
        m_scl = 1'b0; wq(Q);
    endtask

    task automatic bus_stop();
        m_sda = 1'b0; wq(Q);
        m_scl = 1'b1; wq(Q);
        m_sda = 1'b1; wq(Q);
    endtask

    task automatic bus_bit(input logic b, input logic glitch);
        m_sda = b; wq(Q);
        m_scl = 1'b1; wq(Q);
        if (glitch) begin
            m_scl = 1'b0; wq(2);
            m_scl = 1'b1;
        end
        wq(Q);
        m_scl = 1'b0; wq(Q);
    endtask

    task automatic send_byte(input string tag, input logic [7:0] b, input logic ack, input int gbit);
        for (int i = 7; i >= 0; i--) bus_bit(b[i], i == gbit);
        m_sda = 1'b1; wq(Q);
        m_scl = 1'b1; wq(Q);
        check({tag, "_ack"}, 32'(o_sda_oe), 32'(ack));
        wq(Q);
        m_scl = 1'b0; wq(Q);
        check({tag, "_rel"}, 32'(o_sda_oe), 32'd0);
    endtask

    task automatic clear_counts();
        n_valid = 0;
        n_stop = 0;
        busy_seen = 1'b0;
    endtask

    // Output monitor: pops the scoreboard on each o_valid, counts pulses
    always @(negedge clk) begin
        if (o_valid) begin
            n_valid++;
            total++;
            assert (exp_q.size() != 0) passed++;
            else begin
                failed++;
                $error("FAIL sb_underflow: observed o_data %0h expected no o_valid", o_data);
            end
            if (exp_q.size() != 0) check("sb_data", 32'(o_data), 32'(exp_q.pop_front()));
        end
        if (o_stop) n_stop++;
        if (o_busy) busy_seen = 1'b1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1);
    end

    initial begin
        wq(4);
        check("rst_oe", 32'(o_sda_oe), 32'd0);
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_stop", 32'(o_stop), 32'd0);
        check("rst_data", 32'(o_data), 32'h00);
        reset_p = 1'b0;
        wq(4);

        clear_counts();
        bus_start();
        check("t1_busy_pre", 32'(o_busy), 32'd0);
        send_byte("t1_addr", 8'h4E, 1'b1, -1);
        check("t1_busy_addr", 32'(o_busy), 32'd1);
        exp_q.push_back(8'hA5);
        send_byte("t1_data", 8'hA5, 1'b1, -1);
        check("t1_busy_data", 32'(o_busy), 32'd1);
        bus_stop();
        wq(4);
        check("t1_busy_post", 32'(o_busy), 32'd0);
        check("t1_nvalid", 32'(n_valid), 32'd1);
        check("t1_nstop", 32'(n_stop), 32'd1);
        check("t1_data", 32'(o_data), 32'hA5);

        clear_counts();
        bus_start();
        send_byte("t2_addr", 8'h7E, 1'b0, -1);
        send_byte("t2_data", 8'h12, 1'b0, -1);
        bus_stop();
        wq(4);
        check("t2_nvalid", 32'(n_valid), 32'd0);
        check("t2_nstop", 32'(n_stop), 32'd1);
        check("t2_busy_seen", 32'(busy_seen), 32'd0);

        clear_counts();
        bus_start();
        send_byte("t3_addr", 8'h4F, 1'b0, -1);
        send_byte("t3_data", 8'h99, 1'b0, -1);
        bus_stop();
        wq(4);
        check("t3_nvalid", 32'(n_valid), 32'd0);
        check("t3_nstop", 32'(n_stop), 32'd1);
        check("t3_busy_seen", 32'(busy_seen), 32'd0);

        clear_counts();
        bus_start();
        send_byte("t4_addr1", 8'h4E, 1'b1, -1);
        exp_q.push_back(8'h3C);
        send_byte("t4_data1", 8'h3C, 1'b1, -1);
        for (int i = 0; i < 4; i++) bus_bit(1'b1, 1'b0);
        bus_start();
        check("t4_busy_rs", 32'(o_busy), 32'd1);
        send_byte("t4_addr2", 8'h4E, 1'b1, -1);
        exp_q.push_back(8'h81);
        send_byte("t4_data2", 8'h81, 1'b1, -1);
        bus_stop();
        wq(4);
        check("t4_nvalid", 32'(n_valid), 32'd2);
        check("t4_nstop", 32'(n_stop), 32'd1);
        check("t4_data", 32'(o_data), 32'h81);

        clear_counts();
        bus_start();
        for (int i = 7; i >= 0; i--) bus_bit(8'h4E >> i, 1'b0);
        check("t5_ack_on", 32'(o_sda_oe), 32'd1);
        reset_p = 1'b1;
        #1;
        check("t5_async_oe", 32'(o_sda_oe), 32'd0);
        check("t5_async_busy", 32'(o_busy), 32'd0);
        wq(3);
        reset_p = 1'b0;
        wq(4);
        check("t5_nvalid_rst", 32'(n_valid), 32'd0);
        bus_start();
        send_byte("t5_addr", 8'h4E, 1'b1, -1);
        exp_q.push_back(8'h55);
        send_byte("t5_data", 8'h55, 1'b1, -1);
        bus_stop();
        wq(4);
        check("t5_nvalid", 32'(n_valid), 32'd1);
        check("t5_data", 32'(o_data), 32'h55);

`ifdef I2C_TARGET_FILTER_EN
        clear_counts();
        bus_start();
        send_byte("t6_addr", 8'h4E, 1'b1, -1);
        exp_q.push_back(8'hC3);
        send_byte("t6_data", 8'hC3, 1'b1, 3);
        bus_stop();
        wq(4);
        check("t6_nvalid", 32'(n_valid), 32'd1);
        check("t6_data", 32'(o_data), 32'hC3);
`endif

        check("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
